// File: rtl/dds_pkg.sv
// Shared DDS definitions: sample width, DAC frame layout and
// the serialiser state encoding.
package dds_pkg;

    localparam int WAVE_W      = 12;
    localparam int DAC_FRAME_W = 16;
    localparam int DAC_CFG_W   = 4;

    localparam logic [DAC_CFG_W-1:0] DAC_CFG = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        LDAC
    } dac_state_e;

endpackage

// File: rtl/dac_spi_tx_if.sv
// Sample handshake between the DDS output mux (master)
// and the DAC serialiser (slave).
interface dac_spi_tx_if #(
    parameter int WAVE_W = dds_pkg::WAVE_W
);

    logic [WAVE_W-1:0] sample_i;
    logic              sample_valid_i;
    logic              ready_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        input  ready_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        output ready_o
    );

endinterface

// File: rtl/dac_spi_tx_tick.sv
// Half-period timer for SCLK: emits a one-cycle tick every
// HALF_DIV enabled cycles, restartable from any state.
module sclk_tick_gen #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(HALF_DIV - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick_o = en_i & ~restart_i & (cnt_q == 8'd0);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = RELOAD;
        end else if (en_i) begin
            cnt_d = (cnt_q == 8'd0) ? RELOAD : cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 12-bit DDS samples into MCP4921-style SPI mode-0
// frames and pulses LDAC once each frame is complete.
module dac_spi_tx #(
    parameter int                WAVE_W   = dds_pkg::WAVE_W,
    parameter int                CFG_W    = dds_pkg::DAC_CFG_W,
    parameter logic [CFG_W-1:0]  CFG      = dds_pkg::DAC_CFG,
    parameter int                HALF_DIV = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    dac_spi_tx_if.slave  bus,
    output logic         sclk_o,
    output logic         mosi_o,
    output logic         cs_n_o,
    output logic         ldac_n_o,
    output logic         overrun_o,
    input  logic         overrun_clr_i
);

    import dds_pkg::*;

    localparam int FW = DAC_FRAME_W;
    localparam logic [4:0] LAST_BIT = 5'(FW - 1);

    dac_state_e    state_q;
    logic [FW-1:0] shreg_q;
    logic [4:0]    bit_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          cs_n_q;
    logic          ldac_n_q;
    logic          ready_q;
    logic          ovr_q;
    logic          ovr_d;

    logic [FW-1:0] frame;
    logic          accept;
    logic          tick;

    assign frame  = {CFG, bus.sample_i};
    assign accept = bus.sample_valid_i & ready_q;

    sclk_tick_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (state_q != IDLE),
        .restart_i (accept),
        .tick_o    (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= 5'd0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            ldac_n_q <= 1'b1;
            ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= SETUP;
                        shreg_q <= frame;
                        mosi_q  <= frame[FW-1];
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        bit_q   <= 5'd0;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            // Bit 0 stays on MOSI through the CS hold phase.
                            if (bit_q != LAST_BIT) begin
                                shreg_q <= shreg_q << 1;
                                mosi_q  <= shreg_q[FW-2];
                            end
                        end else if (bit_q == LAST_BIT) begin
                            state_q <= GAP;
                            cs_n_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 5'd1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        state_q  <= LDAC;
                        ldac_n_q <= 1'b0;
                    end
                end
                LDAC: begin
                    if (tick) begin
                        state_q  <= IDLE;
                        ldac_n_q <= 1'b1;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Setting wins over a simultaneous clear.
    assign ovr_d = (bus.sample_valid_i & ~ready_q)
                 | (ovr_q & ~overrun_clr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.ready_o = ready_q;
    assign sclk_o      = sclk_q;
    assign mosi_o      = mosi_q;
    assign cs_n_o      = cs_n_q;
    assign ldac_n_o    = ldac_n_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: three instances (H=1,2,3) observed
// through a selectable mux and checked against a frame model.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  = 1'b0;
    logic [11:0] sample = 12'h000;
    logic        valid  = 1'b0;
    logic        clr    = 1'b0;
    logic [1:0]  idx    = 2'd1;

    int vectors     = 0;
    int miscompares = 0;

    logic [2:0] sclk_w, mosi_w, cs_w, ldac_w, ovr_w, rdy_w;
    logic sclk, mosi, cs_n, ldac_n, ovr, ready;

    dac_spi_tx_if #(.WAVE_W(12)) bus1 ();
    dac_spi_tx_if #(.WAVE_W(12)) bus2 ();
    dac_spi_tx_if #(.WAVE_W(12)) bus3 ();

    assign bus1.sample_i       = sample;
    assign bus2.sample_i       = sample;
    assign bus3.sample_i       = sample;
    assign bus1.sample_valid_i = valid & (idx == 2'd0);
    assign bus2.sample_valid_i = valid & (idx == 2'd1);
    assign bus3.sample_valid_i = valid & (idx == 2'd2);
    assign rdy_w = {bus3.ready_o, bus2.ready_o, bus1.ready_o};

    dac_spi_tx #(.HALF_DIV(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .sclk_o(sclk_w[0]), .mosi_o(mosi_w[0]),
        .cs_n_o(cs_w[0]), .ldac_n_o(ldac_w[0]),
        .overrun_o(ovr_w[0]),
        .overrun_clr_i(clr & (idx == 2'd0))
    );

    dac_spi_tx #(.HALF_DIV(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .sclk_o(sclk_w[1]), .mosi_o(mosi_w[1]),
        .cs_n_o(cs_w[1]), .ldac_n_o(ldac_w[1]),
        .overrun_o(ovr_w[1]),
        .overrun_clr_i(clr & (idx == 2'd1))
    );

    dac_spi_tx #(.HALF_DIV(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .sclk_o(sclk_w[2]), .mosi_o(mosi_w[2]),
        .cs_n_o(cs_w[2]), .ldac_n_o(ldac_w[2]),
        .overrun_o(ovr_w[2]),
        .overrun_clr_i(clr & (idx == 2'd2))
    );

    assign sclk   = sclk_w[idx];
    assign mosi   = mosi_w[idx];
    assign cs_n   = cs_w[idx];
    assign ldac_n = ldac_w[idx];
    assign ovr    = ovr_w[idx];
    assign ready  = rdy_w[idx];

    // Pin trace, index n = state after the n-th edge past accept.
    logic tr_cs   [0:255];
    logic tr_sclk [0:255];
    logic tr_mosi [0:255];
    logic tr_ldac [0:255];
    logic tr_rdy  [0:255];

    // Starts at a negedge with ready expected high; ends at the
    // negedge where ready is seen high again.
    task automatic run_frame(
        input  logic [1:0]  i,
        input  logic [11:0] s,
        input  int          ovr_at,
        input  logic [11:0] ovr_s,
        input  logic        clr_same,
        output int          len
    );
        int h;
        h = int'(i) + 1;
        idx = i;
        sample = s;
        valid = 1'b1;
        clr = 1'b0;
        #1;
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready h=%0d got=%b want=1", h, ready);
        end
        @(negedge clk);
        valid = 1'b0;
        sample = 12'($urandom);
        len = -1;
        for (int n = 0; n < 40 * h + 10; n++) begin
            tr_cs[n]   = cs_n;
            tr_sclk[n] = sclk;
            tr_mosi[n] = mosi;
            tr_ldac[n] = ldac_n;
            tr_rdy[n]  = ready;
            if (ready === 1'b1) begin
                len = n;
                break;
            end
            valid = (n == ovr_at);
            if (n == ovr_at) sample = ovr_s;
            clr = clr_same && (n == ovr_at);
            @(negedge clk);
        end
        valid = 1'b0;
        clr = 1'b0;
        vectors++;
        if (len < 0) begin
            miscompares++;
            $display("FAIL frame_timeout h=%0d got=none want=%0d",
                     h, 35 * h);
        end
    endtask

    // Decodes the captured trace as an SPI mode-0 slave would.
    task automatic check_frame(
        input int          h,
        input int          len,
        input logic [15:0] exp,
        input string       tag
    );
        logic [15:0] got;
        int rises, first_rise, last_fall, cs_up, ld_lo, ld_len;
        bit stable;
        got = '0;
        rises = 0;
        first_rise = -1;
        last_fall = -1;
        cs_up = -1;
        ld_lo = -1;
        ld_len = 0;
        stable = 1'b1;
        for (int n = 1; n <= len; n++) begin
            if (tr_sclk[n] && !tr_sclk[n-1] && !tr_cs[n]) begin
                got = {got[14:0], tr_mosi[n]};
                rises++;
                if (first_rise < 0) first_rise = n;
                for (int k = n - h; k < n + h; k++)
                    if (k >= 0 && k <= len && tr_mosi[k] !== tr_mosi[n])
                        stable = 1'b0;
            end
            if (!tr_sclk[n] && tr_sclk[n-1]) last_fall = n;
            if (tr_cs[n] && !tr_cs[n-1] && cs_up < 0) cs_up = n;
            if (!tr_ldac[n]) begin
                if (ld_lo < 0) ld_lo = n;
                ld_len++;
            end
        end
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s data got=%h want=%h", tag, got, exp);
        end
        vectors++;
        if (rises != 16) begin
            miscompares++;
            $display("FAIL %s rises got=%0d want=16", tag, rises);
        end
        vectors++;
        if (len != 35 * h) begin
            miscompares++;
            $display("FAIL %s length got=%0d want=%0d", tag, len, 35 * h);
        end
        vectors++;
        if (tr_cs[0] !== 1'b0 || first_rise != h) begin
            miscompares++;
            $display("FAIL %s cs_setup got=%0d want=%0d", tag, first_rise, h);
        end
        vectors++;
        if (cs_up - last_fall != h) begin
            miscompares++;
            $display("FAIL %s cs_hold got=%0d want=%0d",
                     tag, cs_up - last_fall, h);
        end
        vectors++;
        if (ld_lo - cs_up != h || ld_len != h) begin
            miscompares++;
            $display("FAIL %s ldac got=%0d/%0d want=%0d/%0d",
                     tag, ld_lo - cs_up, ld_len, h, h);
        end
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL %s mosi_stable got=0 want=1", tag);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        vectors++;
        if ({cs_n, ldac_n, sclk, mosi, ready} !== 5'b11001) begin
            miscompares++;
            $display("FAIL %s pins got=%b want=11001", tag,
                     {cs_n, ldac_n, sclk, mosi, ready});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            idx = 2'(i);
            #1;
            check_idle_pins("reset");
            vectors++;
            if (ovr !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ovr h=%0d got=%b want=0", i + 1, ovr);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int len;
        @(negedge clk);
        run_frame(2'd1, 12'hA5C, -1, 12'h000, 1'b0, len);
        check_frame(2, len, 16'h3A5C, "single_h2");
    endtask

    task automatic test_boundary();
        int len;
        @(negedge clk);
        run_frame(2'd0, 12'h000, -1, 12'h000, 1'b0, len);
        check_frame(1, len, 16'h3000, "zero_h1");
        @(negedge clk);
        run_frame(2'd0, 12'hFFF, -1, 12'h000, 1'b0, len);
        check_frame(1, len, 16'h3FFF, "full_h1");
    endtask

    task automatic test_back_to_back();
        int len;
        logic rose;
        @(negedge clk);
        run_frame(2'd1, 12'h123, -1, 12'h000, 1'b0, len);
        check_frame(2, len, 16'h3123, "b2b_first");
        rose = (len > 0) ? !tr_rdy[len-1] : 1'b0;
        run_frame(2'd1, 12'h456, -1, 12'h000, 1'b0, len);
        check_frame(2, len, 16'h3456, "b2b_second");
        vectors++;
        if (!rose) begin
            miscompares++;
            $display("FAIL b2b_first_ready_cycle got=0 want=1");
        end
        vectors++;
        if (ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_overrun got=%b want=0", ovr);
        end
    endtask

    task automatic test_overrun();
        int len;
        @(negedge clk);
        run_frame(2'd1, 12'h111, 10, 12'h777, 1'b0, len);
        check_frame(2, len, 16'h3111, "overrun_frame");
        repeat (5) @(negedge clk);
        vectors++;
        if (ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky got=%b want=1", ovr);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        vectors++;
        if (ovr !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear got=%b want=0", ovr);
        end
        run_frame(2'd1, 12'h222, 6, 12'h999, 1'b1, len);
        check_frame(2, len, 16'h3222, "overrun_setclr");
        vectors++;
        if (ovr !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set_wins got=%b want=1", ovr);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_timing_h3();
        int len;
        logic [11:0] s;
        s = 12'($urandom);
        @(negedge clk);
        run_frame(2'd2, s, -1, 12'h000, 1'b0, len);
        check_frame(3, len, {4'b0011, s}, "timing_h3");
    endtask

    task automatic test_random();
        int len;
        logic [15:0] exp_q[$];
        logic [1:0]  h_q[$];
        logic [11:0] s;
        logic [1:0]  i;
        for (int t = 0; t < 8; t++) begin
            s = 12'($urandom);
            i = 2'($urandom_range(0, 2));
            exp_q.push_back({4'b0011, s});
            h_q.push_back(i);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_frame(i, s, -1, 12'h000, 1'b0, len);
            check_frame(int'(h_q.pop_front()) + 1, len,
                        exp_q.pop_front(), "random");
        end
    endtask

    task automatic test_reset_midframe();
        int len;
        @(negedge clk);
        idx = 2'd1;
        sample = 12'h5A5;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_pins("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_pins("after_reset");
        run_frame(2'd1, 12'h0F0, -1, 12'h000, 1'b0, len);
        check_frame(2, len, 16'h30F0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_overrun();
        test_timing_h3();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
